// File: rtl/sfr_slave_regbank.sv
// sfr_slave_regbank: paged SFR register bank behind a simple request/ack slave port.
// Optional feature macro: SFR_SLV_WAIT_EN adds a WAITCFG register at 0xFE that
// inserts W (0..15) wait cycles before each acknowledge. Without it, every
// access acknowledges one cycle after the request is first sampled.
//
// state | meaning
// IDLE  | no access in progress, waiting for sfrwe|sfroe
// WAIT  | access accepted, counting down W wait cycles
// ACK   | sfrack high for exactly this cycle, read data valid

`ifndef SFR_ADDR_WIDTH
`define SFR_ADDR_WIDTH 8
`endif
`ifndef SFR_DATA_WIDTH
`define SFR_DATA_WIDTH 8
`endif

module sfr_slave_regbank #(
  parameter int ADDR_W   = `SFR_ADDR_WIDTH,
  parameter int DATA_W   = `SFR_DATA_WIDTH,
  parameter int PAGE_NUM = 4,
  parameter int REG_NUM  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ADDR_W-1:0]                   sfraddr,
  input  logic                                sfrwe,
  input  logic                                sfroe,
  input  logic [DATA_W-1:0]                   sfrdatao,
  output logic [DATA_W-1:0]                   sfrdatai,
  output logic                                sfrack,
  output logic [$clog2(PAGE_NUM)-1:0]         sfr_page_sel,
  output logic                                sfr_err,
  output logic [PAGE_NUM*REG_NUM*DATA_W-1:0]  reg_q
);

  localparam int PS_W = $clog2(PAGE_NUM);
  localparam int RI_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [ADDR_W-1:0] REG_LIM      = ADDR_W'(REG_NUM);
  localparam logic [ADDR_W-1:0] ADDR_PAGESEL = ADDR_W'(8'hFF);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [PAGE_NUM][REG_NUM];
  logic [DATA_W-1:0] rd_data;
  logic              req;
  logic              ack_now;
  logic              hit_reg;
  logic              hit_page;
  logic              wr_en;
  logic              rd_en;
  logic              conflict;

`ifdef SFR_SLV_WAIT_EN
  localparam logic [ADDR_W-1:0] ADDR_WAITCFG = ADDR_W'(8'hFE);
  logic [3:0] wait_cfg;
  logic [3:0] wait_cnt;
  logic       hit_wait;
  assign hit_wait = (sfraddr == ADDR_WAITCFG);
  // The edge that raises sfrack is the only edge where the bus is sampled.
  assign ack_now  = ((state == ST_IDLE) && req && (wait_cfg == 4'd0)) ||
                    ((state == ST_WAIT) && (wait_cnt == 4'd0));
`else
  assign ack_now  = (state == ST_IDLE) && req;
`endif

  assign req      = sfrwe | sfroe;
  assign hit_reg  = (sfraddr < REG_LIM);
  assign hit_page = (sfraddr == ADDR_PAGESEL);
  assign conflict = sfrwe & sfroe;
  assign wr_en    = ack_now & sfrwe & ~sfroe;
  assign rd_en    = ack_now & sfroe & ~sfrwe;

  // Read mux: paged registers, then the global control registers, else zero.
  always_comb begin
    rd_data = '0;
    if (hit_reg) begin
      rd_data = regs[sfr_page_sel][sfraddr[RI_W-1:0]];
    end else if (hit_page) begin
      rd_data = DATA_W'(sfr_page_sel);
`ifdef SFR_SLV_WAIT_EN
    end else if (hit_wait) begin
      rd_data = DATA_W'(wait_cfg);
`endif
    end
  end

  // Access FSM with registered ack, read data and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sfrack   <= 1'b0;
      sfrdatai <= '0;
      sfr_err  <= 1'b0;
`ifdef SFR_SLV_WAIT_EN
      wait_cnt <= 4'd0;
`endif
    end else begin
      sfrack   <= 1'b0;
      sfrdatai <= '0;
      if (ack_now) begin
        sfrack <= 1'b1;
        if (rd_en)    sfrdatai <= rd_data;
        if (conflict) sfr_err  <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (req) begin
`ifdef SFR_SLV_WAIT_EN
            if (wait_cfg == 4'd0) begin
              state <= ST_ACK;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= wait_cfg - 4'd1;
            end
`else
            state <= ST_ACK;
`endif
          end
        end
`ifdef SFR_SLV_WAIT_EN
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_ACK;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
`endif
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register file and global control registers, written only at the ack edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PAGE_NUM; p++) begin
        for (int r = 0; r < REG_NUM; r++) begin
          regs[p][r] <= '0;
        end
      end
      sfr_page_sel <= '0;
`ifdef SFR_SLV_WAIT_EN
      wait_cfg     <= 4'd0;
`endif
    end else if (wr_en) begin
      if (hit_reg) begin
        regs[sfr_page_sel][sfraddr[RI_W-1:0]] <= sfrdatao;
      end else if (hit_page) begin
        sfr_page_sel <= sfrdatao[PS_W-1:0];
`ifdef SFR_SLV_WAIT_EN
      end else if (hit_wait) begin
        wait_cfg <= sfrdatao[3:0];
`endif
      end
    end
  end

  for (genvar p = 0; p < PAGE_NUM; p++) begin : g_page
    for (genvar r = 0; r < REG_NUM; r++) begin : g_reg
      assign reg_q[(p*REG_NUM+r)*DATA_W +: DATA_W] = regs[p][r];
    end
  end

endmodule

// File: doc/sfr_slave_regbank.md
SFR_SLAVE_REGBANK -- requirements
Module: sfr_slave_regbank

Interface
REQ-001 Parameter ADDR_W, default 8, SFR address width; SHALL equal `SFR_ADDR_WIDTH.
REQ-002 Parameter DATA_W, default 8, SFR data width; SHALL equal `SFR_DATA_WIDTH.
REQ-003 Parameter PAGE_NUM, default 4, number of register pages; SHALL be a power of 2, >= 2.
REQ-004 Parameter REG_NUM, default 16, registers per page, mapped at addresses 0..REG_NUM-1; SHALL be <= 0xF0.
REQ-005 Port clk  input  1  sole clock; all logic SHALL be rising-edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port sfraddr  input  ADDR_W  access address from master.
REQ-008 Port sfrwe  input  1  write request, held by master until sfrack sampled.
REQ-009 Port sfroe  input  1  read request, held by master until sfrack sampled.
REQ-010 Port sfrdatao  input  DATA_W  write data from master.
REQ-011 Port sfrdatai  output  DATA_W  read data to master.
REQ-012 Port sfrack  output  1  single-cycle access acknowledge.
REQ-013 Port sfr_page_sel  output  $clog2(PAGE_NUM)  current page, driven from PAGESEL register.
REQ-014 Port sfr_err  output  1  sticky protocol-error flag.
REQ-015 Port reg_q  output  PAGE_NUM*REG_NUM*DATA_W  flattened register contents, page-major, register 0 at LSBs.

Function
REQ-016 Request = sfrwe | sfroe; address, data, sfrwe and sfroe SHALL be sampled only at the edge that raises sfrack.
REQ-017 FSM states IDLE, WAIT, ACK; IDLE->ACK on request when wait count W=0; IDLE->WAIT on request when W>0; WAIT->ACK after W cycles in WAIT; ACK->IDLE unconditionally.
REQ-018 sfrack SHALL be registered and high exactly one cycle, in state ACK; ack latency = W+1 cycles from first edge sampling request high.
REQ-019 Request seen in the cycle after ACK SHALL be treated as a new access (master deasserts in the cycle after sampling sfrack).
REQ-020 Request dropped while in WAIT: SHALL still complete to ACK, with no write and sfrdatai = 0.
REQ-021 Write to address A < REG_NUM SHALL update register [sfr_page_sel][A] at the edge raising sfrack.
REQ-022 Address 0xFF = PAGESEL, global (not paged); write loads sfrdatao[$clog2(PAGE_NUM)-1:0]; read returns it zero-extended.
REQ-023 Read SHALL load sfrdatai at the edge raising sfrack; sfrdatai SHALL be held for that cycle and SHALL be 0 in all other cycles.
REQ-024 Unmapped address: SHALL ack normally, ignore write, read 0, leave sfr_err unchanged.
REQ-025 sfrwe and sfroe both high at the sampling edge: SHALL ack, perform no write, return sfrdatai = 0, set sfr_err.
REQ-026 sfr_err SHALL clear only on rst.
REQ-027 A page change SHALL take effect for the next access; the PAGESEL-writing access itself is unpaged.

Reset
REQ-028 On rst high at a clock edge: state = IDLE, sfrack = 0, sfrdatai = 0, sfr_err = 0, sfr_page_sel = 0, all registers = 0, W = 0.
REQ-029 rst mid-access SHALL abort the access with no ack and no write; the access is not resumed after rst.

Configuration
REQ-030 Macro SFR_SLV_WAIT_EN defined: address 0xFE = WAITCFG, global; bits [3:0] hold W (0..15); R/W, reset 0; a new W applies from the next access.
REQ-031 Macro SFR_SLV_WAIT_EN undefined: W fixed at 0, no WAIT state logic, 0xFE is unmapped per REQ-024.

Verification
REQ-032 Write 0x5A to addr 0x03 (page 0), then read 0x03 -> each sfrack exactly 1 cycle after request; read sfrdatai = 0x5A; reg_q[31:24] = 0x5A.
REQ-033 Write 0x02 to 0xFF, write 0xC3 to 0x03, read 0xFF -> sfr_page_sel = 2; page-2 reg 3 = 0xC3; page-0 reg 3 unchanged; read returns 0x02.
REQ-034 With SFR_SLV_WAIT_EN: write 0x04 to 0xFE, then read 0x00 -> sfrack 5 cycles after request; without macro, read 0xFE -> 0x00 in 1 cycle.
REQ-035 sfrwe=sfroe=1, addr 0x01, data 0xFF -> ack in 1 cycle; sfrdatai = 0; register unchanged; sfr_err = 1 until rst.
REQ-036 Write to 0x80; with W=3 assert rst in second WAIT cycle -> unmapped: ack, no state change; rst case: no sfrack, all outputs at reset values next cycle.
